// File: rtl/packed_array_pkg.sv
// packed_array_pkg: default sizes, element/array types and FSM states for packed_array_writer
package packed_array_pkg;
  localparam int DEF_NUM_ELEMS = 32;
  localparam int DEF_ELEM_W = 39;
  localparam int DEF_IDX_W = 11;
  localparam logic [DEF_ELEM_W-1:0] DEF_FILL_VALUE = 39'd114514;
  typedef logic [DEF_ELEM_W-1:0] elem_t;
  typedef logic [DEF_NUM_ELEMS-1:0][DEF_ELEM_W-1:0] arr_t;
  typedef enum logic {IDLE, FILL} state_t;
endpackage

// File: rtl/packed_array_writer.sv
// packed_array_writer: range-checked single-element writes into a packed array plus a sequential bulk fill
module packed_array_writer
  import packed_array_pkg::*;
#(
  parameter int NUM_ELEMS = DEF_NUM_ELEMS,
  parameter int ELEM_W = DEF_ELEM_W,
  parameter int IDX_W = DEF_IDX_W,
  parameter logic [ELEM_W-1:0] FILL_VALUE = ELEM_W'(DEF_FILL_VALUE)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        init_start,
  output logic                        init_busy,
  output logic                        fill_done,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [IDX_W-1:0]            wr_idx,
  input  logic [ELEM_W-1:0]           wr_data,
  output logic                        wr_err,
  output logic [IDX_W-1:0]            err_idx,
  output logic [7:0]                  err_cnt,
  output logic [NUM_ELEMS*ELEM_W-1:0] array_o
);
  localparam int PTR_W = NUM_ELEMS > 1 ? $clog2(NUM_ELEMS) : 1;
  state_t r_state, w_next;
  logic [PTR_W-1:0] r_ptr;
  logic [NUM_ELEMS-1:0][ELEM_W-1:0] r_arr;
  logic r_fill_done, r_wr_err;
  logic [IDX_W-1:0] r_err_idx;
  logic [7:0] r_err_cnt;
  logic w_last, w_acc, w_in_range;
  assign wr_ready = r_state == IDLE && !init_start;
  always_comb begin
    w_last = r_ptr == PTR_W'(NUM_ELEMS - 1);
    w_acc = wr_valid && wr_ready;
    // zero-extended full-width compare so high index bits are never dropped
    w_in_range = 32'(wr_idx) < 32'(NUM_ELEMS);
    w_next = r_state == IDLE ? (init_start ? FILL : IDLE) : (w_last ? IDLE : FILL);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_arr <= '0;
      r_fill_done <= 1'b0;
      r_wr_err <= 1'b0;
      r_err_idx <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_fill_done <= r_state == FILL && w_last;
      r_wr_err <= w_acc && !w_in_range;
      if (r_state == FILL) begin
        r_arr[r_ptr] <= FILL_VALUE;
        r_ptr <= w_last ? '0 : r_ptr + PTR_W'(1);
      end else if (w_acc && w_in_range) begin
        r_arr[wr_idx[PTR_W-1:0]] <= wr_data;
      end
      if (w_acc && !w_in_range) begin
        r_err_idx <= wr_idx;
        r_err_cnt <= r_err_cnt + {7'd0, r_err_cnt != 8'hff};
      end
    end
  end
  assign init_busy = r_state == FILL;
  assign fill_done = r_fill_done;
  assign wr_err = r_wr_err;
  assign err_idx = r_err_idx;
  assign err_cnt = r_err_cnt;
  assign array_o = r_arr;
endmodule

// File: tb/tb_packed_array_writer.sv
// tb_packed_array_writer: randomized scoreboard bench with an element-array reference model
module tb_packed_array_writer;
  import packed_array_pkg::*;
  localparam int N = 32;
  localparam int W = 39;
  localparam int IW = 11;
  localparam logic [W-1:0] FV = 39'd114514;
  typedef logic [N*W-1:0] flat_t;
  typedef struct packed {
    flat_t arr;
    logic err;
    logic [IW-1:0] eidx;
    logic [7:0] ecnt;
  } exp_t;
  logic clk = 0, rst = 1, init_start = 0, wr_valid = 0;
  logic [IW-1:0] wr_idx = '0;
  logic [W-1:0] wr_data = '0;
  logic init_busy, fill_done, wr_ready, wr_err;
  logic [IW-1:0] err_idx;
  logic [7:0] err_cnt;
  flat_t array_o;
  exp_t sbq[$];
  flat_t fillq[$];
  exp_t e_cur;
  logic [W-1:0] m[N];
  logic [IW-1:0] m_eidx;
  int m_ecnt;
  int vectors = 0, miscompares = 0, busy_n = 0;
  logic acc_q = 0;
  always #5 clk = ~clk;
  packed_array_writer dut (
    .clk(clk), .rst(rst), .init_start(init_start), .init_busy(init_busy), .fill_done(fill_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_data(wr_data),
    .wr_err(wr_err), .err_idx(err_idx), .err_cnt(err_cnt), .array_o(array_o)
  );
  function automatic flat_t pack_model();
    flat_t r;
    for (int i = 0; i < N; i++) r[i*W +: W] = m[i];
    return r;
  endfunction
  task automatic check(input string name, input flat_t act, input flat_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void model_write(input logic [IW-1:0] idx, input logic [W-1:0] d);
    exp_t e;
    if (int'(idx) < N) m[idx] = d;
    else begin
      m_eidx = idx;
      m_ecnt = m_ecnt < 255 ? m_ecnt + 1 : 255;
    end
    e.arr = pack_model();
    e.err = int'(idx) >= N;
    e.eidx = m_eidx;
    e.ecnt = 8'(m_ecnt);
    sbq.push_back(e);
  endfunction
  // monitor: every accepted write produces exactly one response the following cycle
  always @(posedge clk) acc_q <= wr_valid && wr_ready && !rst;
  always @(negedge clk) begin
    if (rst) busy_n = 0;
    else if (init_busy) busy_n++;
    if (acc_q) begin
      if (sbq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL write_sb: got response expected none");
      end else begin
        e_cur = sbq.pop_front();
        check("write_array", array_o, e_cur.arr);
        check("write_err", flat_t'(wr_err), flat_t'(e_cur.err));
        check("write_err_idx", flat_t'(err_idx), flat_t'(e_cur.eidx));
        check("write_err_cnt", flat_t'(err_cnt), flat_t'(e_cur.ecnt));
      end
    end else if (wr_err) begin
      vectors++; miscompares++;
      $display("FAIL spurious_wr_err: got 1 expected 0");
    end
    if (fill_done) begin
      if (fillq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL spurious_fill_done: got 1 expected 0");
      end else begin
        check("fill_array", array_o, fillq.pop_front());
        check("fill_busy_cycles", flat_t'(busy_n), flat_t'(N));
        busy_n = 0;
      end
    end
  end
  task automatic do_reset();
    rst = 1; wr_valid = 0; init_start = 0;
    @(posedge clk); #1;
    rst = 0;
    foreach (m[i]) m[i] = '0;
    m_eidx = '0; m_ecnt = 0;
    sbq.delete(); fillq.delete();
    check("rst_array", array_o, pack_model());
    check("rst_busy", flat_t'(init_busy), 0);
    check("rst_fill_done", flat_t'(fill_done), 0);
    check("rst_wr_err", flat_t'(wr_err), 0);
    check("rst_err_idx", flat_t'(err_idx), 0);
    check("rst_err_cnt", flat_t'(err_cnt), 0);
    check("rst_wr_ready", flat_t'(wr_ready), 1);
  endtask
  task automatic wr(input logic [IW-1:0] idx, input logic [W-1:0] d, output int waits);
    wr_valid = 1; wr_idx = idx; wr_data = d; waits = 0;
    while (!wr_ready && waits < 200) begin @(posedge clk); #1; waits++; end
    if (!wr_ready) begin
      vectors++; miscompares++;
      $display("FAIL wr_timeout: wr_ready got 0 expected 1");
      wr_valid = 0;
      return;
    end
    model_write(idx, d);
    @(posedge clk); #1;
    wr_valid = 0;
  endtask
  task automatic fill_start();
    init_start = 1; #1;
    check("ready_vs_init", flat_t'(wr_ready), 0);
    foreach (m[i]) m[i] = FV;
    fillq.push_back(pack_model());
    @(posedge clk); #1;
    init_start = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (init_busy && n < 200) begin @(posedge clk); #1; n++; end
    check("fill_timeout", flat_t'(init_busy), 0);
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  initial begin
    int w;
    logic [IW-1:0] ri;
    do_reset();
    // bulk fill with an ignored re-start in the middle
    fill_start();
    idle(5);
    check("busy_mid_fill", flat_t'(init_busy), 1);
    check("ready_in_fill", flat_t'(wr_ready), 0);
    init_start = 1;
    idle(1);
    init_start = 0;
    wait_idle();
    idle(3);
    do_reset();
    wr(11'd12, 39'd7, w);
    idle(2);
    for (int i = 0; i < N; i++) begin
      wr(IW'(i), W'(3 * i), w);
      check("b2b_ready", flat_t'(w), 0);
    end
    idle(2);
    do_reset();
    wr(11'd32, 39'h55, w);
    wr(11'd2047, 39'h66, w);
    idle(2);
    check("two_errs", flat_t'(err_cnt), 2);
    // init_start and a pending write in the same cycle
    do_reset();
    wr_valid = 1; wr_idx = 11'd5; wr_data = 39'd99;
    fill_start();
    wr(11'd5, 39'd99, w);
    check("write_after_fill_waited", flat_t'(w >= N - 1), 1);
    idle(2);
    // reset while the fill pointer is at 10
    fill_start();
    idle(10);
    do_reset();
    idle(40);
    // randomized writes with occasional fills
    for (int k = 0; k < 300; k++) begin
      ri = $urandom_range(0, 3) == 0 ? IW'($urandom_range(N, 2047)) : IW'($urandom_range(0, N - 1));
      wr(ri, W'({$urandom, $urandom}), w);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      if (k % 75 == 40) begin fill_start(); wait_idle(); end
    end
    idle(3);
    // error counter saturation
    do_reset();
    for (int k = 0; k < 260; k++) wr(IW'($urandom_range(N, 2047)), W'($urandom), w);
    idle(2);
    check("err_cnt_sat", flat_t'(err_cnt), 255);
    wr(11'd3, 39'd1234, w);
    idle(3);
    check("sb_drained", flat_t'(sbq.size()), 0);
    check("fill_drained", flat_t'(fillq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
